// File: rtl/button_event_decoder.sv
// Turns the debounced button level into registered one-cycle press/release/short/long/repeat events.
// Define DOUBLE_CLICK_EN to add double-click detection (WAIT_SECOND / SECOND_PRESSED states).
module button_event_decoder #(
    parameter int unsigned TICK_DIV  = 27000,
    parameter int unsigned LONG_MS   = 600,
    parameter int unsigned REPEAT_MS = 150,
    parameter int unsigned DOUBLE_MS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic double_pulse
);

    localparam logic [15:0] DIV_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
    localparam logic [15:0] DBL_LAST  = 16'(DOUBLE_MS - 1);
    localparam logic [15:0] REP_THR   = 16'(REPEAT_MS);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_SECOND,
        S_SECOND_PRESSED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q;
    logic [15:0] tick_q;
    logic [15:0] thr_last;
    logic        thr_hit, rep_hit, tmr_clr;
    logic        held_d, press_d, rel_d, short_d, long_d, rep_d, dbl_d;

    // One shared threshold comparator: the double-click window only matters in WAIT_SECOND.
    always_comb thr_last = (state_q == S_WAIT_SECOND) ? DBL_LAST : LONG_LAST;

    assign thr_hit = (presc_q == DIV_LAST) && (tick_q == thr_last);
    // Repeat fires one edge after tick_cnt lands on REPEAT_MS, giving a REPEAT_MS*TICK_DIV+1 period.
    assign rep_hit = (tick_q == REP_THR);

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (!btn_level) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (btn_level) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                end
            end
            S_PRESSED: begin
                if (!btn_level) begin
                    rel_d = 1'b1;
`ifdef DOUBLE_CLICK_EN
                    state_d = S_WAIT_SECOND;
`else
                    state_d = S_IDLE;
                    short_d = 1'b1;
`endif
                end else if (thr_hit) begin
                    state_d = S_LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (!btn_level) begin
                    state_d = S_IDLE;
                    rel_d   = 1'b1;
                end else if (rep_hit) begin
                    rep_d = 1'b1;
                end
            end
`ifdef DOUBLE_CLICK_EN
            S_WAIT_SECOND: begin
                if (btn_level) begin
                    state_d = S_SECOND_PRESSED;
                    press_d = 1'b1;
                end else if (thr_hit) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_SECOND_PRESSED: begin
                if (!btn_level) begin
                    state_d = S_IDLE;
                    rel_d   = 1'b1;
                    dbl_d   = 1'b1;
                end else if (thr_hit) begin
                    state_d = S_LONG_HELD;
                    long_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_INIT;
        endcase
    end

    assign tmr_clr = (state_d != state_q) || rep_d;
    assign held_d  = (state_d == S_PRESSED) || (state_d == S_LONG_HELD) ||
                     (state_d == S_SECOND_PRESSED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            presc_q       <= '0;
            tick_q        <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_pulse  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tmr_clr) begin
                presc_q <= '0;
                tick_q  <= '0;
            end else if (presc_q == DIV_LAST) begin
                presc_q <= '0;
                // Saturate so a button left idle for a long time never aliases a threshold.
                if (tick_q != 16'hFFFF) tick_q <= tick_q + 16'd1;
            end else begin
                presc_q <= presc_q + 16'd1;
            end
            held          <= held_d;
            press_pulse   <= press_d;
            release_pulse <= rel_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
            repeat_pulse  <= rep_d;
            double_pulse  <= dbl_d;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios plus random press/release runs
// checked every cycle against an elapsed-time reference model.
module tb_button_event_decoder;

    localparam int DIV  = 4;
    localparam int LONG = 5;
    localparam int REP  = 3;
    localparam int DBL  = 4;
`ifdef DOUBLE_CLICK_EN
    localparam bit DCE = 1'b1;
`else
    localparam bit DCE = 1'b0;
`endif
    localparam int SHORT_DLY = DCE ? DBL * DIV : 0;

    localparam int MI = 0, MIDLE = 1, MP = 2, ML = 3, MW = 4, MS = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_level;
    logic held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, double_pulse;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;
    int m_st;
    int m_t;
    logic [6:0] exp_v;

    button_event_decoder #(
        .TICK_DIV (DIV),
        .LONG_MS  (LONG),
        .REPEAT_MS(REP),
        .DOUBLE_MS(DBL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_level    (btn_level),
        .held         (held),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .double_pulse (double_pulse)
    );

    always #5 clk = ~clk;

    // {held, press, release, short, long, repeat, double}
    assign obs = {held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, double_pulse};

    task automatic model_reset();
        m_st  = MI;
        m_t   = 0;
        exp_v = '0;
    endtask

    // m_t counts clock edges since the current phase began; events are plain elapsed-time tests.
    task automatic model_edge(input logic b);
        logic [6:0] e;
        e = '0;
        case (m_st)
            MI: if (!b) m_st = MIDLE;
            MIDLE: if (b) begin m_st = MP; m_t = 0; e[5] = 1'b1; end
            MP: begin
                m_t++;
                if (!b) begin
                    e[4] = 1'b1;
                    if (DCE) begin m_st = MW; m_t = 0; end
                    else begin m_st = MIDLE; e[3] = 1'b1; end
                end else if (m_t == LONG * DIV) begin
                    m_st = ML; m_t = 0; e[2] = 1'b1;
                end
            end
            ML: begin
                m_t++;
                if (!b) begin m_st = MIDLE; e[4] = 1'b1; end
                else if (m_t % (REP * DIV + 1) == 0) e[1] = 1'b1;
            end
            MW: begin
                m_t++;
                if (b) begin m_st = MS; m_t = 0; e[5] = 1'b1; end
                else if (m_t == DBL * DIV) begin m_st = MIDLE; e[3] = 1'b1; end
            end
            MS: begin
                m_t++;
                if (!b) begin m_st = MIDLE; e[4] = 1'b1; e[0] = 1'b1; end
                else if (m_t == LONG * DIV) begin m_st = ML; m_t = 0; e[2] = 1'b1; end
            end
            default: m_st = MI;
        endcase
        e[6] = (m_st == MP) || (m_st == ML) || (m_st == MS);
        exp_v = e;
    endtask

    // Drive at the falling edge, let the DUT sample at the rising edge, return at the next falling edge.
    task automatic step(input logic b);
        btn_level = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int evt_n = 0;
        rst = 1'b1;
        btn_level = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL reset_state got %b want 0000000", obs); end
        model_reset();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_held_btn step %0d got %b want %b", k, obs, exp_v); end
            if (obs != 7'b0) evt_n++;
        end
        checks++;
        if (evt_n != 0) begin errors++; $display("FAIL reset_no_events got %0d active cycles want 0", evt_n); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_drop step %0d got %b want %b", k, obs, exp_v); end
        end
        step(1'b1);
        checks++;
        if (press_pulse !== 1'b1 || held !== 1'b1) begin
            errors++; $display("FAIL reset_first_press got press=%b held=%b want 1 1", press_pulse, held);
        end
        for (int k = 1; k <= 22; k++) begin
            step(k <= 2);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_tail step %0d got %b want %b", k, obs, exp_v); end
        end
    endtask

    task automatic test_short_click();
        int press_at = 0, rel_at = 0, short_at = 0, held_n = 0;
        for (int k = 1; k <= 30; k++) begin
            step(k <= 8);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL short_click step %0d got %b want %b", k, obs, exp_v); end
            if (press_pulse && press_at == 0) press_at = k;
            if (release_pulse) rel_at = k;
            if (short_pulse) short_at = k;
            if (held) held_n++;
        end
        checks++;
        if (press_at != 1) begin errors++; $display("FAIL short_press_at got %0d want 1", press_at); end
        checks++;
        if (rel_at != 9) begin errors++; $display("FAIL short_release_at got %0d want 9", rel_at); end
        checks++;
        if (short_at != 9 + SHORT_DLY) begin errors++; $display("FAIL short_at got %0d want %0d", short_at, 9 + SHORT_DLY); end
        checks++;
        if (held_n != 8) begin errors++; $display("FAIL short_held_cycles got %0d want 8", held_n); end
    endtask

    task automatic test_long_hold();
        int long_at = 0, rel_at = 0, short_n = 0, rep_n = 0, rep1 = 0, rep2 = 0;
        for (int k = 1; k <= 80; k++) begin
            step(k <= 60);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL long_hold step %0d got %b want %b", k, obs, exp_v); end
            if (long_pulse) long_at = k;
            if (release_pulse) rel_at = k;
            if (short_pulse) short_n++;
            if (repeat_pulse) begin
                rep_n++;
                if (rep_n == 1) rep1 = k;
                if (rep_n == 2) rep2 = k;
            end
        end
        checks++;
        if (long_at != 21) begin errors++; $display("FAIL long_at got %0d want 21", long_at); end
        checks++;
        if (rep1 != 34 || rep2 != 47) begin errors++; $display("FAIL repeat_at got %0d,%0d want 34,47", rep1, rep2); end
        checks++;
        if (rep_n != 3) begin errors++; $display("FAIL repeat_count got %0d want 3", rep_n); end
        checks++;
        if (rel_at != 61 || short_n != 0) begin
            errors++; $display("FAIL long_release got rel=%0d short=%0d want 61 0", rel_at, short_n);
        end
    endtask

    task automatic test_release_on_threshold();
        int long_n = 0, rel_at = 0, short_at = 0;
        for (int k = 1; k <= 40; k++) begin
            step(k <= 20);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL thr_release step %0d got %b want %b", k, obs, exp_v); end
            if (long_pulse) long_n++;
            if (release_pulse) rel_at = k;
            if (short_pulse) short_at = k;
        end
        checks++;
        if (long_n != 0) begin errors++; $display("FAIL thr_no_long got %0d want 0", long_n); end
        checks++;
        if (rel_at != 21 || short_at != 21 + SHORT_DLY) begin
            errors++; $display("FAIL thr_release_short got rel=%0d short=%0d want 21 %0d", rel_at, short_at, 21 + SHORT_DLY);
        end
    endtask

    task automatic test_release_beats_repeat();
        int rep_n = 0, rep1 = 0, rel_at = 0;
        for (int k = 1; k <= 60; k++) begin
            step(k <= 46);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL rel_vs_rep step %0d got %b want %b", k, obs, exp_v); end
            if (repeat_pulse) begin rep_n++; if (rep_n == 1) rep1 = k; end
            if (release_pulse) rel_at = k;
        end
        checks++;
        if (rep_n != 1 || rep1 != 34 || rel_at != 47) begin
            errors++; $display("FAIL rel_beats_rep got reps=%0d first=%0d rel=%0d want 1 34 47", rep_n, rep1, rel_at);
        end
    endtask

    task automatic test_double_click();
        int gaps[3] = '{10, 17, 16};
        for (int g = 0; g < 3; g++) begin
            int runs[4];
            int k = 0, press_n = 0, dbl_n = 0, dbl_at = 0, short_n = 0, short1 = 0;
            runs = '{6, gaps[g], 6, 25};
            for (int r = 0; r < 4; r++) begin
                for (int j = 0; j < runs[r]; j++) begin
                    k++;
                    step(r % 2 == 0);
                    checks++;
                    if (obs !== exp_v) begin errors++; $display("FAIL dbl_gap%0d step %0d got %b want %b", gaps[g], k, obs, exp_v); end
                    if (press_pulse) press_n++;
                    if (double_pulse) begin dbl_n++; dbl_at = k; end
                    if (short_pulse) begin short_n++; if (short_n == 1) short1 = k; end
                end
            end
            checks++;
            if (press_n != 2) begin errors++; $display("FAIL dbl_gap%0d presses got %0d want 2", gaps[g], press_n); end
            if (DCE && gaps[g] != 17) begin
                checks++;
                if (dbl_n != 1 || dbl_at != gaps[g] + 13 || short_n != 0) begin
                    errors++; $display("FAIL dbl_gap%0d got dbl=%0d at %0d short=%0d want 1 at %0d 0",
                                       gaps[g], dbl_n, dbl_at, short_n, gaps[g] + 13);
                end
            end else begin
                checks++;
                if (dbl_n != 0 || short_n != 2 || short1 != 7 + SHORT_DLY) begin
                    errors++; $display("FAIL single_gap%0d got dbl=%0d short=%0d first=%0d want 0 2 %0d",
                                       gaps[g], dbl_n, short_n, short1, 7 + SHORT_DLY);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int evt_n = 0;
        for (int k = 1; k <= 25; k++) begin
            step(1'b1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL arst_enter step %0d got %b want %b", k, obs, exp_v); end
        end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL arst_pre_held got %b want 1", held); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL arst_immediate got %b want 0000000", obs); end
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL arst_hold got %b want 0000000", obs); end
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL arst_after step %0d got %b want %b", k, obs, exp_v); end
            if (obs != 7'b0) evt_n++;
        end
        checks++;
        if (evt_n != 0) begin errors++; $display("FAIL arst_no_events got %0d want 0", evt_n); end
        step(1'b0);
        step(1'b0);
        step(1'b1);
        checks++;
        if (press_pulse !== 1'b1) begin errors++; $display("FAIL arst_repress got %b want 1", press_pulse); end
        for (int k = 1; k <= 22; k++) begin
            step(k <= 3);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL arst_tail step %0d got %b want %b", k, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        int k = 0;
        for (int r = 0; r < 60; r++) begin
            int len;
            len = $urandom_range(1, 45);
            for (int j = 0; j < len; j++) begin
                k++;
                step(r % 2 == 0);
                checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL random step %0d got %b want %b", k, obs, exp_v); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_level = 1'b1;
        model_reset();
        test_reset();
        test_short_click();
        test_long_hold();
        test_release_on_threshold();
        test_release_beats_repeat();
        test_double_click();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
